bin_swap_ctrl: RTL and testbench

Sequencer that owns bin residency for the SAT engine. On a bin-switch request it writes back the resident bin when that bin is dirty, then loads the requested bin. It drives the start/done handshakes of the bin store and bin load blocks, arbitrates the shared clause/var/lvl-state BRAM ports between engine, store and load, and acknowledges the engine once the new bin is resident.

---
 rtl/bin_swap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_bin_swap_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_swap_ctrl.sv
// bin_swap_ctrl: owns bin residency for the SAT engine.
// On a bin-switch request the resident bin is written back when dirty, then the
// requested bin is loaded. The block hands out the start pulses for the store and
// load blocks, selects which of engine/store/load drives the shared BRAM ports,
// and acknowledges the engine once the requested bin is resident.
module bin_swap_ctrl #(
  parameter int WIDTH_BIN_ID   = 10,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int WIDTH_TO       = 10,
  parameter int WIDTH_SWAP_CNT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_bin_i,
  input  logic [WIDTH_BIN_ID-1:0]   req_bin_num_i,
  input  logic                      dirty_i,
  output logic                      req_ready_o,
  output logic                      ack_o,
  output logic [WIDTH_BIN_ID-1:0]   cur_bin_o,
  output logic                      start_store_o,
  output logic [WIDTH_BIN_ID-1:0]   store_bin_num_o,
  input  logic                      done_store_i,
  output logic                      start_load_o,
  output logic [WIDTH_BIN_ID-1:0]   load_bin_num_o,
  input  logic                      done_load_i,
  output logic [1:0]                ram_owner_o,
  output logic                      err_timeout_o,
  output logic [WIDTH_SWAP_CNT-1:0] swap_cnt_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STORE_REQ  = 3'd1,
    STORE_WAIT = 3'd2,
    LOAD_REQ   = 3'd3,
    LOAD_WAIT  = 3'd4,
    ACK        = 3'd5,
    ERR        = 3'd6
  } state_e;

  localparam logic [1:0] OWNER_ENGINE = 2'b00;
  localparam logic [1:0] OWNER_STORE  = 2'b01;
  localparam logic [1:0] OWNER_LOAD   = 2'b10;

  // Last counter value still allowed in a WAIT state; one more idle edge means timeout.
  localparam logic [WIDTH_TO-1:0] TO_LAST = WIDTH_TO'(TIMEOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [WIDTH_TO-1:0]       to_q, to_d;
  logic [WIDTH_BIN_ID-1:0]   req_bin_q;
  logic [WIDTH_BIN_ID-1:0]   req_bin_eff;
  logic [WIDTH_BIN_ID-1:0]   cur_bin_q;
  logic [WIDTH_BIN_ID-1:0]   store_bin_num_q;
  logic [WIDTH_BIN_ID-1:0]   load_bin_num_q;
  logic [WIDTH_SWAP_CNT-1:0] swap_cnt_q;
  logic                      req_ready_q;
  logic                      ack_q;
  logic                      start_store_q;
  logic                      start_load_q;
  logic [1:0]                ram_owner_q;
  logic                      err_q;

  // On a clean miss LOAD_REQ is entered straight from IDLE, before req_bin_q holds the request.
  assign req_bin_eff = (state_q == IDLE) ? req_bin_num_i : req_bin_q;

  // Next-state and timeout counter; done beats timeout because it is tested first.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (req_bin_i && (req_bin_num_i != '0)) begin
          if (req_bin_num_i == cur_bin_q) begin
            state_d = ACK;
          end else if (dirty_i && (cur_bin_q != '0)) begin
            state_d = STORE_REQ;
          end else begin
            state_d = LOAD_REQ;
          end
        end
      end
      STORE_REQ: begin
        state_d = STORE_WAIT;
        to_d    = '0;
      end
      STORE_WAIT: begin
        if (done_store_i) begin
          state_d = LOAD_REQ;
        end else if (to_q == TO_LAST) begin
          state_d = ERR;
        end else begin
          to_d = to_q + WIDTH_TO'(1);
        end
      end
      LOAD_REQ: begin
        state_d = LOAD_WAIT;
        to_d    = '0;
      end
      LOAD_WAIT: begin
        if (done_load_i) begin
          state_d = ACK;
        end else if (to_q == TO_LAST) begin
          state_d = ERR;
        end else begin
          to_d = to_q + WIDTH_TO'(1);
        end
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // State register plus outputs registered from the next state, so each output is valid in the cycle of its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      to_q            <= '0;
      req_bin_q       <= '0;
      cur_bin_q       <= '0;
      store_bin_num_q <= '0;
      load_bin_num_q  <= '0;
      swap_cnt_q      <= '0;
      req_ready_q     <= 1'b1;
      ack_q           <= 1'b0;
      start_store_q   <= 1'b0;
      start_load_q    <= 1'b0;
      ram_owner_q     <= OWNER_ENGINE;
      err_q           <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_q          <= to_d;
      req_ready_q   <= (state_d == IDLE);
      ack_q         <= (state_d == ACK);
      start_store_q <= (state_d == STORE_REQ);
      start_load_q  <= (state_d == LOAD_REQ);
      err_q         <= (state_d == ERR);
      if ((state_d == STORE_REQ) || (state_d == STORE_WAIT)) begin
        ram_owner_q <= OWNER_STORE;
      end else if ((state_d == LOAD_REQ) || (state_d == LOAD_WAIT)) begin
        ram_owner_q <= OWNER_LOAD;
      end else begin
        ram_owner_q <= OWNER_ENGINE;
      end
      if ((state_q == IDLE) && (state_d != IDLE)) begin
        req_bin_q <= req_bin_num_i;
      end
      if (state_d == STORE_REQ) begin
        store_bin_num_q <= cur_bin_q;
      end
      if (state_d == LOAD_REQ) begin
        load_bin_num_q <= req_bin_eff;
      end
      if ((state_q == LOAD_WAIT) && (state_d == ACK)) begin
        cur_bin_q  <= req_bin_q;
        swap_cnt_q <= swap_cnt_q + WIDTH_SWAP_CNT'(1);
      end
      if (state_d == ERR) begin
        cur_bin_q <= '0;
      end
    end
  end

  assign req_ready_o     = req_ready_q;
  assign ack_o           = ack_q;
  assign cur_bin_o       = cur_bin_q;
  assign start_store_o   = start_store_q;
  assign store_bin_num_o = store_bin_num_q;
  assign start_load_o    = start_load_q;
  assign load_bin_num_o  = load_bin_num_q;
  assign ram_owner_o     = ram_owner_q;
  assign err_timeout_o   = err_q;
  assign swap_cnt_o      = swap_cnt_q;

endmodule

// File: tb/tb_bin_swap_ctrl.sv
// Testbench for bin_swap_ctrl: directed scenarios followed by randomized bin
// requests, checked cycle by cycle against a transaction-level reference model
// (resident bin, swap count, error flag) that derives expected outputs from the
// request/store/load/ack sequencing rules.
module tb_bin_swap_ctrl;

  localparam int T = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_bin_i = 1'b0;
  logic [9:0]  req_bin_num_i = '0;
  logic        dirty_i = 1'b0;
  logic        done_store_i = 1'b0;
  logic        done_load_i = 1'b0;
  logic        req_ready_o;
  logic        ack_o;
  logic [9:0]  cur_bin_o;
  logic        start_store_o;
  logic [9:0]  store_bin_num_o;
  logic        start_load_o;
  logic [9:0]  load_bin_num_o;
  logic [1:0]  ram_owner_o;
  logic        err_timeout_o;
  logic [15:0] swap_cnt_o;

  int compared = 0;
  int mismatched = 0;

  int curBin = 0;
  int swapCnt = 0;
  bit errFlag = 0;

  bin_swap_ctrl #(
    .WIDTH_BIN_ID  (10),
    .TIMEOUT_CYCLES(T),
    .WIDTH_TO      (5),
    .WIDTH_SWAP_CNT(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_bin_i      (req_bin_i),
    .req_bin_num_i  (req_bin_num_i),
    .dirty_i        (dirty_i),
    .req_ready_o    (req_ready_o),
    .ack_o          (ack_o),
    .cur_bin_o      (cur_bin_o),
    .start_store_o  (start_store_o),
    .store_bin_num_o(store_bin_num_o),
    .done_store_i   (done_store_i),
    .start_load_o   (start_load_o),
    .load_bin_num_o (load_bin_num_o),
    .done_load_i    (done_load_i),
    .ram_owner_o    (ram_owner_o),
    .err_timeout_o  (err_timeout_o),
    .swap_cnt_o     (swap_cnt_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req_bin_i    = 1'b0;
    done_store_i = 1'b0;
    done_load_i  = 1'b0;
  endtask

  task automatic expectOuts(input string tag, input logic ready, input logic ack,
                            input logic ss, input logic sl, input logic [1:0] owner);
    checkOutput({tag, ".ready"}, req_ready_o, ready);
    checkOutput({tag, ".ack"}, ack_o, ack);
    checkOutput({tag, ".startStore"}, start_store_o, ss);
    checkOutput({tag, ".startLoad"}, start_load_o, sl);
    checkOutput({tag, ".owner"}, ram_owner_o, owner);
    checkOutput({tag, ".err"}, err_timeout_o, errFlag);
    checkOutput({tag, ".cur"}, cur_bin_o, errFlag ? 0 : curBin);
    if (!errFlag) checkOutput({tag, ".swap"}, swap_cnt_o, swapCnt & 16'hFFFF);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".ready"}, req_ready_o, 1);
    checkOutput({tag, ".ack"}, ack_o, 0);
    checkOutput({tag, ".cur"}, cur_bin_o, 0);
    checkOutput({tag, ".startStore"}, start_store_o, 0);
    checkOutput({tag, ".storeBin"}, store_bin_num_o, 0);
    checkOutput({tag, ".startLoad"}, start_load_o, 0);
    checkOutput({tag, ".loadBin"}, load_bin_num_o, 0);
    checkOutput({tag, ".owner"}, ram_owner_o, 0);
    checkOutput({tag, ".err"}, err_timeout_o, 0);
    checkOutput({tag, ".swap"}, swap_cnt_o, 0);
  endtask

  // Asynchronous reset pulse raised between clock edges; outputs must clear before any edge.
  task automatic doReset(input string tag);
    clearInputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    checkReset(tag);
    curBin  = 0;
    swapCnt = 0;
    errFlag = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One WAIT phase: done arrives on the (delay+1)-th WAIT edge, or never if delay >= T.
  task automatic waitPhase(input int delay, input bit isStore, input bit noise, output bit timedOut);
    string tag;
    tag = isStore ? "storeWait" : "loadWait";
    timedOut = 1'b0;
    for (int k = 0; k < T; k++) begin
      expectOuts(tag, 0, 0, 0, 0, isStore ? 2'b01 : 2'b10);
      if (k == delay) begin
        if (isStore) done_store_i = 1'b1;
        else         done_load_i  = 1'b1;
      end else if (noise && ($urandom_range(0, 3) == 0)) begin
        req_bin_i     = 1'b1;
        req_bin_num_i = 10'($urandom_range(1, 7));
        if (isStore) done_load_i  = 1'b1;
        else         done_store_i = 1'b1;
      end
      tick();
      clearInputs();
      if (k == delay) return;
    end
    timedOut = 1'b1;
    errFlag  = 1'b1;
    expectOuts("timeoutErr", 0, 0, 0, 0, 2'b00);
  endtask

  // One engine request carried through to its ack (or ignore / error), checked every cycle.
  task automatic applyStimulus(input int num, input bit dirty, input int sDelay,
                               input int lDelay, input bit noise);
    bit to;
    req_bin_i     = 1'b1;
    req_bin_num_i = 10'(num);
    dirty_i       = dirty;
    tick();
    req_bin_i     = 1'b0;
    req_bin_num_i = 10'($urandom);
    dirty_i       = 1'($urandom);
    if (errFlag) begin
      expectOuts("errHold", 0, 0, 0, 0, 2'b00);
      return;
    end
    if (num == 0) begin
      expectOuts("zeroIgnore", 1, 0, 0, 0, 2'b00);
      return;
    end
    if (num == curBin) begin
      expectOuts("hitAck", 0, 1, 0, 0, 2'b00);
      tick();
      expectOuts("hitReady", 1, 0, 0, 0, 2'b00);
      return;
    end
    if (dirty && (curBin != 0)) begin
      expectOuts("storeReq", 0, 0, 1, 0, 2'b01);
      checkOutput("storeBin", store_bin_num_o, curBin);
      if (noise) begin
        done_store_i = 1'b1;
        done_load_i  = 1'b1;
        req_bin_i    = 1'b1;
      end
      tick();
      clearInputs();
      waitPhase(sDelay, 1'b1, noise, to);
      if (to) return;
    end
    expectOuts("loadReq", 0, 0, 0, 1, 2'b10);
    checkOutput("loadBin", load_bin_num_o, num);
    if (noise) begin
      done_load_i  = 1'b1;
      done_store_i = 1'b1;
      req_bin_i    = 1'b1;
    end
    tick();
    clearInputs();
    waitPhase(lDelay, 1'b0, noise, to);
    if (to) return;
    curBin = num;
    swapCnt++;
    expectOuts("loadAck", 0, 1, 0, 0, 2'b00);
    tick();
    expectOuts("loadReady", 1, 0, 0, 0, 2'b00);
  endtask

  initial begin
    doReset("reset");

    // Empty residency: dirty flag must not trigger a store; load lands after 20 wait cycles.
    applyStimulus(3, 1'b1, 0, 20, 1'b0);
    // Hit on the resident bin.
    applyStimulus(3, 1'b0, 0, 0, 1'b0);
    // Dirty miss: write back 3, then load 5.
    applyStimulus(5, 1'b1, 4, 6, 1'b0);
    // Bin 0 request and stray done in IDLE are ignored.
    applyStimulus(0, 1'b1, 0, 0, 1'b0);
    done_load_i  = 1'b1;
    done_store_i = 1'b1;
    tick();
    clearInputs();
    expectOuts("strayDone", 1, 0, 0, 0, 2'b00);
    // Dirty miss with busy-time requests and foreign done pulses injected.
    applyStimulus(6, 1'b1, 7, 2, 1'b1);

    // Withheld load done: error state, requests ignored until reset.
    applyStimulus(2, 1'b0, 0, T + 5, 1'b0);
    checkOutput("timeoutFlag", err_timeout_o, 1);
    applyStimulus(4, 1'b1, 0, 0, 1'b0);
    doReset("errReset");

    // Reset in the middle of a store wait, then a normal request.
    applyStimulus(7, 1'b0, 0, 3, 1'b0);
    req_bin_i     = 1'b1;
    req_bin_num_i = 10'd9;
    dirty_i       = 1'b1;
    tick();
    clearInputs();
    expectOuts("midStoreReq", 0, 0, 1, 0, 2'b01);
    tick();
    tick();
    expectOuts("midStoreWait", 0, 0, 0, 0, 2'b01);
    doReset("midReset");
    applyStimulus(9, 1'b1, 0, 5, 1'b0);

    // Randomized requests over a small bin range so hits, misses and ignores all occur.
    for (int n = 0; n < 150; n++) begin
      int num;
      int sd;
      int ld;
      num = $urandom_range(0, 7);
      sd  = ($urandom_range(0, 39) == 0) ? T + 2 : $urandom_range(0, T - 1);
      ld  = ($urandom_range(0, 39) == 0) ? T + 2 : $urandom_range(0, T - 1);
      applyStimulus(num, 1'($urandom), sd, ld, 1'($urandom));
      if (errFlag) begin
        applyStimulus($urandom_range(1, 7), 1'($urandom), 0, 0, 1'b0);
        doReset("randReset");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
